// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start, 8 data bits LSB first, stop; CPB = CLK_FREQ/BAUD clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       UART_TXD,
  output logic       busy,
  output logic       tx_done
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(CPB);

  generate
    if (CPB < 2) begin : g_cpb_check
      $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             txd_q, txd_d;
  logic             done_q, done_d;
  logic             rdy_q;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign bit_end  = (cnt_q == CNT_W'(CPB - 1));
  assign in_ready = rdy_q;
  assign UART_TXD = txd_q;
  assign busy     = (state_q != IDLE);
  assign tx_done  = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        txd_d = 1'b1;
        // rdy_q is only ever set while idle and out of reset
        if (in_valid && rdy_q) begin
          state_d = START;
          shreg_d = in_data;
          txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          txd_d   = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = par_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = '0;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          cnt_d   = '0;
          txd_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      rdy_q   <= (state_d == IDLE);
    end
  end

  // Payload registers carry no reset; they are only consumed inside a frame.
  always_ff @(posedge CLOCK_50) begin
    shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLK_FREQ=1000, BAUD=100 (10 clocks per bit).
module tb_uart_tx;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       UART_TXD;
  logic       busy;
  logic       tx_done;

  int vecs = 0;
  int errs = 0;
  int ncyc = 0;
  int starts[$];
  logic prev_busy = 1'b0;

  uart_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .UART_TXD (UART_TXD),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  // Frame-start monitor: records the cycle on which busy rises.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (busy === 1'b1 && prev_busy === 1'b0) starts.push_back(ncyc);
    prev_busy = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_line", UART_TXD, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", tx_done, 0);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 30 && in_ready !== 1'b1; i++) @(negedge clk);
    chk("ready_before_send", in_ready, 1);
  endtask

  // Caller drives in_data/in_valid at a negedge with in_ready high; acceptance is the next posedge.
  task automatic run_frame(input logic [7:0] d, input bit chain, input logic [7:0] nd,
                           input int glitch_k, input int rst_k,
                           output logic [7:0] decoded, output logic par_s);
    logic [NB-1:0] bits;
    for (int i = 0; i < NB; i++) begin
      if (i == 0) bits[i] = 1'b0;
      else if (i <= 8) bits[i] = d[i-1];
      else if (i == NB - 1) bits[i] = 1'b1;
      else bits[i] = ^d;
    end
    decoded = 8'h00;
    par_s   = 1'bx;
    @(posedge clk);
    for (int k = 0; k <= FL; k++) begin
      @(negedge clk);
      if (k == 0 && !chain) in_valid = 1'b0;
      if (k == rst_k + 1) begin
        chk("rst_line", UART_TXD, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_ready", in_ready, 0);
        reset = 1'b0;
        return;
      end
      if (k < FL) begin
        chk("line", UART_TXD, bits[k/CPB]);
        chk("busy_in_frame", busy, 1);
        chk("done_in_frame", tx_done, 0);
        if (k % CPB == CPB / 2) begin
          if (k / CPB >= 1 && k / CPB <= 8) decoded[k/CPB-1] = UART_TXD;
          if (k / CPB == 9) par_s = UART_TXD;
        end
      end else begin
        chk("done_pulse", tx_done, 1);
        chk("busy_after", busy, 0);
        chk("line_after", UART_TXD, 1);
        chk("ready_after", in_ready, 1);
        if (chain) in_data = nd;
      end
      if (k == glitch_k) begin
        in_data  = 8'hFF;
        in_valid = 1'b1;
        chk("ready_while_busy", in_ready, 0);
      end
      if (k == glitch_k + 1) in_valid = 1'b0;
      if (k == rst_k) reset = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] d, input int glitch_k, input int rst_k,
                      output logic [7:0] decoded, output logic par_s);
    wait_ready();
    in_data  = d;
    in_valid = 1'b1;
    run_frame(d, 1'b0, 8'h00, glitch_k, rst_k, decoded, par_s);
  endtask

  initial begin
    logic [7:0] dec, dec2, d;
    logic       ps;
    logic [7:0] rnd[6];
    int         n0;

    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      chk("reset_line", UART_TXD, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", tx_done, 0);
      chk("reset_ready", in_ready, 0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);
    chk("busy_after_reset", busy, 0);

    send(8'h55, -10, -10, dec, ps);
    chk("decode_55", dec, 8'h55);
    idle(3);

    wait_ready();
    n0       = starts.size();
    in_data  = 8'hA5;
    in_valid = 1'b1;
    run_frame(8'hA5, 1'b1, 8'h3C, -10, -10, dec, ps);
    run_frame(8'h3C, 1'b0, 8'h00, -10, -10, dec2, ps);
    chk("decode_A5", dec, 8'hA5);
    chk("decode_3C", dec2, 8'h3C);
    chk("start_count", starts.size() - n0, 2);
    if (starts.size() >= n0 + 2) chk("start_gap", starts[n0+1] - starts[n0], FL + 1);
    idle(3);

    send(8'h00, 45, -10, dec, ps);
    chk("decode_00_glitch", dec, 8'h00);
    idle(FL + 5);

    d = 8'($urandom()) & 8'hF7;
    send(d, -10, 45, dec, ps);
    idle(12);
    send(8'h81, -10, -10, dec, ps);
    chk("decode_81", dec, 8'h81);
    idle(2);

    for (int i = 0; i < 6; i++) rnd[i] = 8'($urandom());
    wait_ready();
    n0       = starts.size();
    in_data  = rnd[0];
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_frame(rnd[i], (i < 5), (i < 5) ? rnd[(i+1)%6] : 8'h00, -10, -10, dec, ps);
      chk("decode_rand", dec, rnd[i]);
    end
    chk("rand_start_count", starts.size() - n0, 6);
    for (int i = 1; i < 6; i++)
      if (starts.size() >= n0 + 6) chk("rand_gap", starts[n0+i] - starts[n0+i-1], FL + 1);
    idle(3);

`ifdef UART_TX_PARITY_EN
    send(8'h07, -10, -10, dec, ps);
    chk("parity_07", ps, 1);
    chk("decode_07", dec, 8'h07);
    send(8'h03, -10, -10, dec, ps);
    chk("parity_03", ps, 0);
    idle(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=%0d expected=%0d", ncyc, 0);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 50000000, meaning the CLOCK_50 frequency in Hz.
REQ-002 The module SHALL have parameter BAUD, default 115200, meaning the line rate in bit/s.
REQ-003 The module SHALL derive CPB = CLK_FREQ/BAUD as an integer with truncation, and SHALL require CPB >= 2.
REQ-004 The module SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: a synchronous, active-high reset.
REQ-006 The module SHALL have port in_data, input, 8 bits: the byte to transmit.
REQ-007 The module SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-009 The module SHALL have port UART_TXD, output, 1 bit: the serial line, idle high.
REQ-010 The module SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-011 The module SHALL have port tx_done, output, 1 bit: a one-cycle pulse at frame end.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY SHALL exist only per REQ-027.
REQ-013 in_ready SHALL be 1 only in IDLE and not in reset.
REQ-014 A byte SHALL be accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-015 On acceptance, in_data SHALL be latched into a shift register and the FSM SHALL go IDLE->START.
REQ-016 UART_TXD SHALL be registered and SHALL go low on the edge that accepts the byte, i.e. visible 1 cycle after acceptance.
REQ-017 Each bit SHALL be held for exactly CPB cycles using a baud counter that counts 0..CPB-1 and is cleared on every state change.
REQ-018 The sequence SHALL be START (0), then DATA (8 bits, LSB first, bit index 0..7 with wrap detected at 7), then optional PARITY, then STOP (1).
REQ-019 The frame SHALL occupy 10*CPB cycles without parity and 11*CPB cycles with parity.
REQ-020 On the last STOP cycle, tx_done SHALL pulse 1 cycle and the FSM SHALL return to IDLE with UART_TXD held at 1.
REQ-021 If in_valid is held continuously, consecutive start bits SHALL be exactly (frame length + 1) cycles apart; no other gap is allowed.
REQ-022 in_valid and in_data SHALL be ignored while busy; a frame in flight SHALL be unaffected by changes on in_data.
REQ-023 busy SHALL equal (state != IDLE).
REQ-024 in_valid=1 coincident with reset=1 SHALL NOT be accepted.

Reset
REQ-025 While reset=1 at an edge, the block SHALL set state=IDLE, UART_TXD=1, busy=0, tx_done=0, in_ready=0 and clear all counters; in_ready SHALL return to 1 on the first edge after reset deasserts.
REQ-026 A reset mid-frame SHALL abort the frame, drive the line to 1 on the next edge and discard the byte; no tx_done pulse SHALL be produced.

Configuration
REQ-027 Macro UART_TX_PARITY_EN:
- Defined: the PARITY state SHALL be inserted between DATA and STOP and SHALL transmit even parity (XOR of the 8 data bits) for CPB cycles.
- Undefined: the PARITY state and its logic SHALL be absent and the frame SHALL be 8N1.

Verification (bench CLK_FREQ=1000, BAUD=100, so CPB=10)
REQ-028 Reset held 3 cycles, then released -> UART_TXD=1, busy=0, tx_done=0 during reset; in_ready=1 on the first edge after release.
REQ-029 Send 0x55, no parity -> line is 0,1,0,1,0,1,0,1,0,1, each for 10 cycles; tx_done pulses at cycle 100 after the start edge; busy is high for 100 cycles.
REQ-030 Send 0xA5 then 0x3C with in_valid held -> start bits 101 cycles apart; sampling at bit centres decodes 0xA5 then 0x3C.
REQ-031 With UART_TX_PARITY_EN defined, send 0x07 -> parity bit = 1, frame = 110 cycles; send 0x03 -> parity bit = 0.
REQ-032 Change in_data to 0xFF and pulse in_valid in the middle of a frame for 0x00 -> 0x00 is transmitted intact and 0xFF is not accepted.
REQ-033 Assert reset at cycle 45 of a frame -> UART_TXD=1 on the next edge, no tx_done pulse, and a following send of 0x81 is correct.
